// File: rtl/adder_response_checker.sv
// adder_response_checker
//   Response-side checker for adder DUTs. Watches the operands driven to the
//   DUT, computes the expected {carry,sum}, delays it by the DUT latency and
//   compares it per vector. Reports a verdict that stays valid until the next
//   start, together with a vector count, an error count and the operands of
//   the first failing vector.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting up to NUM_VECTORS stimulus vectors
//   DRAIN | all vectors accepted, waiting for in-flight compares
//   DONE  | verdict valid, waiting for start
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 begin a run (IDLE/DONE only)
//   stim_valid, a, b      stimulus as applied to the DUT
//   dut_sum, dut_carry    DUT response
//   busy, done, pass      run status / verdict
//   mismatch              1-cycle pulse after a failing compare
//   vec_count, err_count  compares / mismatches this run (err saturates)
//   fail_a, fail_b        operands of the first failing vector
module adder_response_checker #(
  parameter int WIDTH       = 1,
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int REM_W = $clog2(NUM_VECTORS + 1);
  localparam int EXP_W = WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             mismatch_q, mismatch_d;

  logic             start_take;
  logic             accept;
  logic             last_accept;
  logic [EXP_W-1:0] exp_now;
  logic             cmp_valid;
  logic [EXP_W-1:0] cmp_exp;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_fail;
  logic             in_flight;

  assign start_take  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept      = stim_valid && (state_q == S_RUN);
  // rem_q counts down the vectors still to be accepted in this run
  assign last_accept = accept && (rem_q == REM_W'(1));
  assign exp_now     = EXP_W'(a) + EXP_W'(b);

  generate
    if (LATENCY == 0) begin : g_comb
      assign cmp_valid = accept;
      assign cmp_exp   = exp_now;
      assign cmp_a     = a;
      assign cmp_b     = b;
      assign in_flight = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_q, vld_d;
      logic [EXP_W-1:0]   exp_q [LATENCY];
      logic [EXP_W-1:0]   exp_d [LATENCY];
      logic [WIDTH-1:0]   pa_q  [LATENCY];
      logic [WIDTH-1:0]   pa_d  [LATENCY];
      logic [WIDTH-1:0]   pb_q  [LATENCY];
      logic [WIDTH-1:0]   pb_d  [LATENCY];

      always_comb begin
        vld_d[0] = accept;
        exp_d[0] = exp_now;
        pa_d[0]  = a;
        pb_d[0]  = b;
        for (int i = 1; i < LATENCY; i++) begin
          vld_d[i] = vld_q[i-1];
          exp_d[i] = exp_q[i-1];
          pa_d[i]  = pa_q[i-1];
          pb_d[i]  = pb_q[i-1];
        end
        // a new run discards anything still travelling from the old one
        if (start_take) vld_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            exp_q[i] <= '0;
            pa_q[i]  <= '0;
            pb_q[i]  <= '0;
          end
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < LATENCY; i++) begin
            exp_q[i] <= exp_d[i];
            pa_q[i]  <= pa_d[i];
            pb_q[i]  <= pb_d[i];
          end
        end
      end

      // The tail is compared this cycle, so only earlier stages count as
      // still in flight; DRAIN can then leave on the final compare cycle.
      always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) in_flight = in_flight | vld_q[i];
      end

      assign cmp_valid = vld_q[LATENCY-1] && ((state_q == S_RUN) || (state_q == S_DRAIN));
      assign cmp_exp   = exp_q[LATENCY-1];
      assign cmp_a     = pa_q[LATENCY-1];
      assign cmp_b     = pb_q[LATENCY-1];
    end
  endgenerate

  // Case inequality so an X/Z response is reported as a mismatch.
  assign cmp_fail = cmp_valid && ({dut_carry, dut_sum} !== cmp_exp);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    mismatch_d  = 1'b0;

    case (state_q)
      S_RUN:   if (last_accept) state_d = S_DRAIN;
      S_DRAIN: if (!in_flight) state_d = S_DONE;
      default: state_d = state_q;
    endcase

    if (accept) rem_d = rem_q - REM_W'(1);

    if (cmp_valid) begin
      vec_count_d = vec_count_q + CNT_W'(1);
      if (cmp_fail) begin
        mismatch_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
        if (err_count_q == '0) begin
          fail_a_d = cmp_a;
          fail_b_d = cmp_b;
        end
      end
    end

    if (start_take) begin
      state_d     = S_RUN;
      rem_d       = REM_W'(NUM_VECTORS);
      vec_count_d = '0;
      err_count_d = '0;
      fail_a_d    = '0;
      fail_b_d    = '0;
      mismatch_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_count_q == '0);
  assign mismatch  = mismatch_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_adder_response_checker.sv
module tb_adder_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // ---------------- instance 1: half adder, combinational DUT
  logic       start1, sv1, a1, b1, s1, c1, bad1;
  logic       busy1, done1, pass1, mm1, fa1, fb1;
  logic [7:0] vc1, ec1;

  always_comb begin
    {c1, s1} = {1'b0, a1} + {1'b0, b1};
    if (bad1) s1 = 1'b0;
  end

  adder_response_checker #(.WIDTH(1), .LATENCY(0), .NUM_VECTORS(4), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim_valid(sv1), .a(a1), .b(b1),
    .dut_sum(s1), .dut_carry(c1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch(mm1), .vec_count(vc1), .err_count(ec1), .fail_a(fa1), .fail_b(fb1));

  // ---------------- instance 2: 4-bit adder, 2-cycle DUT
  logic       start2, sv2, corrupt2, c2, busy2, done2, pass2, mm2;
  logic [3:0] a2, b2, s2, fa2, fb2;
  logic [4:0] p1_2, p2_2;
  logic [8:0] vc2, ec2;

  always @(posedge clk) begin
    p1_2 <= (corrupt2 && a2 == 4'd7 && b2 == 4'd9) ? 5'd0 : ({1'b0, a2} + {1'b0, b2});
    p2_2 <= p1_2;
  end
  assign {c2, s2} = p2_2;

  adder_response_checker #(.WIDTH(4), .LATENCY(2), .NUM_VECTORS(256), .CNT_W(9)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim_valid(sv2), .a(a2), .b(b2),
    .dut_sum(s2), .dut_carry(c2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch(mm2), .vec_count(vc2), .err_count(ec2), .fail_a(fa2), .fail_b(fb2));

  // ---------------- instance 3: half adder, 2-cycle DUT, 2-bit counters
  logic       start3, sv3, a3, b3, bad3, s3, c3;
  logic       busy3, done3, pass3, mm3, fa3, fb3;
  logic [1:0] p1_3, p2_3, vc3, ec3;

  always @(posedge clk) begin
    p1_3 <= ({1'b0, a3} + {1'b0, b3}) ^ (bad3 ? 2'b11 : 2'b00);
    p2_3 <= p1_3;
  end
  assign {c3, s3} = p2_3;

  adder_response_checker #(.WIDTH(1), .LATENCY(2), .NUM_VECTORS(4), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim_valid(sv3), .a(a3), .b(b3),
    .dut_sum(s3), .dut_carry(c3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch(mm3), .vec_count(vc3), .err_count(ec3), .fail_a(fa3), .fail_b(fb3));

  // ---------------- scoreboard: expected mismatch flag per accepted vector
  bit q1[$];
  bit q2[$];
  int mm1_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every vec_count step that is not a run restart is one compare.
  initial begin
    logic       pb1, pb2, e;
    logic [7:0] pv1;
    logic [8:0] pv2;
    pb1 = 1'b0; pb2 = 1'b0; pv1 = '0; pv2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb1 = 1'b0; pb2 = 1'b0; pv1 = '0; pv2 = '0;
      end else begin
        if (vc1 != pv1 && !(busy1 && !pb1)) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb1_extra_compare actual=vec_count %0d required=no compare", vc1);
          end else begin
            e = q1.pop_front();
            chk("sb1_mismatch", {31'd0, mm1}, {31'd0, e});
          end
        end
        if (vc2 != pv2 && !(busy2 && !pb2)) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb2_extra_compare actual=vec_count %0d required=no compare", vc2);
          end else begin
            e = q2.pop_front();
            chk("sb2_mismatch", {31'd0, mm2}, {31'd0, e});
          end
        end
        if (mm1) mm1_cnt++;
        pb1 = busy1; pv1 = vc1; pb2 = busy2; pv2 = vc2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int inst);
    for (int i = 0; i < 600; i++) begin
      if ((inst == 1 && done1) || (inst == 2 && done2) || (inst == 3 && done3)) return;
      step();
    end
    checks++; errors++;
    $display("FAIL wait_done%0d actual=timeout required=done", inst);
  endtask

  task automatic vec1(input logic a, input logic b, input bit acc);
    sv1 = 1'b1; a1 = a; b1 = b;
    if (acc) q1.push_back(bad1 && (a ^ b));
    step();
    sv1 = 1'b0;
  endtask

  task automatic vec2(input logic [3:0] a, input logic [3:0] b);
    sv2 = 1'b1; a2 = a; b2 = b;
    q2.push_back(corrupt2 && a == 4'd7 && b == 4'd9);
    step();
    sv2 = 1'b0;
  endtask

  task automatic vec3(input logic a, input logic b);
    sv3 = 1'b1; a3 = a; b3 = b;
    step();
    sv3 = 1'b0;
  endtask

  initial begin
    int mm_base;
    rst_n = 1'b0;
    start1 = 0; sv1 = 0; a1 = 0; b1 = 0; bad1 = 0;
    start2 = 0; sv2 = 0; a2 = 0; b2 = 0; corrupt2 = 0;
    start3 = 0; sv3 = 0; a3 = 0; b3 = 0; bad3 = 0;
    repeat (3) step();

    // reset state
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_done", {31'd0, done1}, 0);
    chk("rst_pass", {31'd0, pass1}, 0);
    chk("rst_mismatch", {31'd0, mm1}, 0);
    chk("rst_vec_count", {24'd0, vc1}, 0);
    chk("rst_err_count", {24'd0, ec1}, 0);
    chk("rst_busy2", {31'd0, busy2}, 0);
    rst_n = 1'b1;
    step();

    // stimulus in IDLE is ignored
    sv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    repeat (3) step();
    sv1 = 1'b0;
    chk("idle_ignore_vec_count", {24'd0, vc1}, 0);
    chk("idle_busy", {31'd0, busy1}, 0);

    // T1: good half adder, plus ignored vectors in DRAIN and DONE
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("t1_start_busy", {31'd0, busy1}, 1);
    chk("t1_start_done", {31'd0, done1}, 0);
    vec1(0, 0, 1); vec1(0, 1, 1); vec1(1, 0, 1); vec1(1, 1, 1);
    chk("t1_drain_busy", {31'd0, busy1}, 1);
    vec1(1, 0, 0);
    vec1(1, 1, 0);
    wait_done(1);
    chk("t1_done", {31'd0, done1}, 1);
    chk("t1_pass", {31'd0, pass1}, 1);
    chk("t1_vec_count", {24'd0, vc1}, 4);
    chk("t1_err_count", {24'd0, ec1}, 0);

    // restart from DONE with a sum-stuck-at-0 DUT (T2)
    bad1 = 1'b1;
    mm_base = mm1_cnt;
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("restart_done_drop", {31'd0, done1}, 0);
    chk("restart_busy", {31'd0, busy1}, 1);
    chk("restart_vec_clear", {24'd0, vc1}, 0);
    vec1(0, 0, 1); vec1(0, 1, 1); vec1(1, 0, 1); vec1(1, 1, 1);
    wait_done(1);
    chk("t2_err_count", {24'd0, ec1}, 2);
    chk("t2_fail_a", {31'd0, fa1}, 0);
    chk("t2_fail_b", {31'd0, fb1}, 1);
    chk("t2_pass", {31'd0, pass1}, 0);
    chk("t2_vec_count", {24'd0, vc1}, 4);
    chk("t2_pulses", mm1_cnt - mm_base, 2);
    bad1 = 1'b0;

    // T3: exhaustive 4-bit, latency 2, good then 7+9 corrupted
    for (int run = 0; run < 2; run++) begin
      corrupt2 = (run == 1);
      start2 = 1'b1; step(); start2 = 1'b0;
      for (int i = 0; i < 256; i++) vec2(4'(i >> 4), 4'(i));
      wait_done(2);
      chk("t3_vec_count", {23'd0, vc2}, 256);
      if (run == 0) begin
        chk("t3_pass_good", {31'd0, pass2}, 1);
        chk("t3_err_good", {23'd0, ec2}, 0);
      end else begin
        chk("t3_err_corrupt", {23'd0, ec2}, 1);
        chk("t3_fail_a", {28'd0, fa2}, 7);
        chk("t3_fail_b", {28'd0, fb2}, 9);
        chk("t3_pass_corrupt", {31'd0, pass2}, 0);
      end
    end
    corrupt2 = 1'b0;

    // T4: every vector wrong, 2-bit error count saturates at 3
    bad3 = 1'b1;
    start3 = 1'b1; step(); start3 = 1'b0;
    vec3(0, 0); vec3(0, 1); vec3(1, 0); vec3(1, 1);
    wait_done(3);
    chk("t4_err_sat", {30'd0, ec3}, 3);
    chk("t4_pass", {31'd0, pass3}, 0);
    chk("t4_vec_wrap", {30'd0, vc3}, 0);

    // T5: reset with a compare done and one vector still in flight
    start3 = 1'b1; step(); start3 = 1'b0;
    vec3(1, 1); vec3(0, 1);
    step();
    chk("t5_pre_vec_count", {30'd0, vc3}, 1);
    chk("t5_pre_fail_a", {31'd0, fa3}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy3}, 0);
    chk("t5_rst_done", {31'd0, done3}, 0);
    chk("t5_rst_pass", {31'd0, pass3}, 0);
    chk("t5_rst_mismatch", {31'd0, mm3}, 0);
    chk("t5_rst_vec_count", {30'd0, vc3}, 0);
    chk("t5_rst_err_count", {30'd0, ec3}, 0);
    chk("t5_rst_fail_a", {31'd0, fa3}, 0);
    chk("t5_rst_fail_b", {31'd0, fb3}, 0);
    step();
    rst_n = 1'b1;
    step();
    start3 = 1'b1; step(); start3 = 1'b0;
    repeat (4) step();
    chk("t5_no_stale_vec", {30'd0, vc3}, 0);
    chk("t5_no_stale_err", {30'd0, ec3}, 0);
    bad3 = 1'b0;
    vec3(0, 0); vec3(0, 1); vec3(1, 0); vec3(1, 1);
    wait_done(3);
    chk("t5_pass", {31'd0, pass3}, 1);
    chk("t5_err_count", {30'd0, ec3}, 0);

    repeat (3) step();
    chk("sb1_drained", q1.size(), 0);
    chk("sb2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
